// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared constants and response type for the instruction ROM pipeline
//
// Purpose : default geometry/latency constants and the response payload carried
//           through every pipeline stage.
// Contents: ROM_NPC_DEF, ROM_NINST_DEF, ROM_LATENCY_DEF, rom_rsp_t, rom_rsp_idle().
package rom_pkg;

    localparam int ROM_NPC_DEF     = 6;
    localparam int ROM_NINST_DEF   = 32;
    localparam int ROM_LATENCY_DEF = 2;

    // inst is sized for the default word width; narrower words are zero-extended.
    typedef struct packed {
        logic [ROM_NINST_DEF-1:0] inst;
        logic                     err;
    } rom_rsp_t;

    // Payload loaded into a stage that carries a bubble, so idle stages read as zero.
    function automatic rom_rsp_t rom_rsp_idle();
        return '0;
    endfunction

endpackage

// File: rtl/rom_stage.sv
// rtl/rom_stage.sv - one response pipeline register (valid + payload) with hold and flush
//
// Purpose : delays a ROM response by one cycle when the pipeline advances.
// Ports   : clk, rst_n  - clock, asynchronous active-low reset
//           flush       - clears the stage (wins over advance)
//           advance     - load d_* when high, hold otherwise
//           d_valid, d_data - upstream stage
//           q_valid, q_data - registered stage contents
module rom_stage
    import rom_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     advance,
    input  logic     d_valid,
    input  rom_rsp_t d_data,
    output logic     q_valid,
    output rom_rsp_t q_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= rom_rsp_idle();
        end else if (flush) begin
            q_valid <= 1'b0;
            q_data  <= rom_rsp_idle();
        end else if (advance) begin
            q_valid <= d_valid;
            q_data  <= d_valid ? d_data : rom_rsp_idle();
        end
    end

endmodule

// File: rtl/inst_rom_pipe.sv
// rtl/inst_rom_pipe.sv - pipelined instruction ROM with valid/ready request and response
//
// Purpose : constant ROM (word i = i+1) read through LATENCY register stages with
//           backpressure, flush, chip enable and out-of-range error reporting.
// Ports   : i_clk, i_rst_n               - clock, asynchronous active-low reset
//           i_ce, i_req_valid, i_addr    - request side (o_req_ready handshake)
//           i_flush                      - discard every in-flight request
//           o_rsp_valid, i_rsp_ready     - response handshake
//           o_inst, o_err                - response payload (zero when not valid)
module inst_rom_pipe
    import rom_pkg::*;
#(
    parameter int NPC     = ROM_NPC_DEF,
    parameter int NINST   = ROM_NINST_DEF,
    parameter int DEPTH   = 2 ** NPC,
    parameter int LATENCY = ROM_LATENCY_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic             i_req_valid,
    input  logic [NPC-1:0]   i_addr,
    output logic             o_req_ready,
    input  logic             i_flush,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [NINST-1:0] o_inst,
    output logic             o_err
);

    localparam int             WORDS     = 2 ** NPC;
    localparam logic [NPC:0]   DEPTH_LIM = (NPC + 1)'(DEPTH);

    // Full address space is populated; unimplemented words read as zero, which is
    // also the value returned alongside o_err.
    logic [NINST-1:0] rom_mem [WORDS];

    for (genvar i = 0; i < WORDS; i++) begin : g_rom
        if (i < DEPTH) begin : g_impl
            assign rom_mem[i] = NINST'(i + 1);
        end else begin : g_hole
            assign rom_mem[i] = '0;
        end
    end

    logic     advance;
    logic     accept;
    logic     addr_oob;
    rom_rsp_t rd_data;

    // Array-read stage registers.
    logic     s0_valid;
    rom_rsp_t s0_data;

    // Stage chain: element 0 mirrors the array-read stage, the rest are rom_stage outputs.
    logic     chain_valid [LATENCY];
    rom_rsp_t chain_data  [LATENCY];

    assign advance     = !o_rsp_valid || i_rsp_ready;
    assign o_req_ready = advance;
    assign accept      = i_req_valid && i_ce && advance && !i_flush;
    assign addr_oob    = {1'b0, i_addr} >= DEPTH_LIM;

    always_comb begin
        rd_data      = rom_rsp_idle();
        rd_data.err  = addr_oob;
        rd_data.inst = addr_oob ? '0 : ROM_NINST_DEF'(rom_mem[i_addr]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_valid <= 1'b0;
            s0_data  <= rom_rsp_idle();
        end else if (i_flush) begin
            s0_valid <= 1'b0;
            s0_data  <= rom_rsp_idle();
        end else if (advance) begin
            // A non-accepting advance loads a bubble.
            s0_valid <= accept;
            s0_data  <= accept ? rd_data : rom_rsp_idle();
        end
    end

    assign chain_valid[0] = s0_valid;
    assign chain_data[0]  = s0_data;

    for (genvar s = 1; s < LATENCY; s++) begin : g_stage
        rom_stage u_stage (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .flush   (i_flush),
            .advance (advance),
            .d_valid (chain_valid[s-1]),
            .d_data  (chain_data[s-1]),
            .q_valid (chain_valid[s]),
            .q_data  (chain_data[s])
        );
    end

    assign o_rsp_valid = chain_valid[LATENCY-1];
    assign o_inst      = o_rsp_valid ? chain_data[LATENCY-1].inst[NINST-1:0] : '0;
    assign o_err       = o_rsp_valid && chain_data[LATENCY-1].err;

endmodule
